// File: rtl/cpu_run_ctrl.sv
// Run/halt controller for a CPU core: reset sequencing, halt/resume, cycle counting.
// Optional single-step support is compiled in with the SINGLE_STEP_EN macro.
module cpu_run_ctrl #(
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             continue_req,
  input  logic             halt_req,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic             pwr,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_STEP = 2'd3
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic             cont_prev_q, cont_prev_d;
  logic             cont_rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             cpu_en_q, cpu_en_d;
  logic             pwr_q, pwr_d;
  logic             halted_q, halted_d;
`ifdef SINGLE_STEP_EN
  logic             step_prev_q, step_prev_d;
  logic             step_rise;
`endif

  assign cont_rise = continue_req & ~cont_prev_q;
`ifdef SINGLE_STEP_EN
  assign step_rise = step & ~step_prev_q;
`endif

  // State register; edge detectors reset high so levels held through reset are not edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      hold_q      <= '0;
      cont_prev_q <= 1'b1;
      cnt_q       <= '0;
      cpu_rst_q   <= 1'b1;
      cpu_en_q    <= 1'b0;
      pwr_q       <= 1'b0;
      halted_q    <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_prev_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cont_prev_q <= cont_prev_d;
      cnt_q       <= cnt_d;
      cpu_rst_q   <= cpu_rst_d;
      cpu_en_q    <= cpu_en_d;
      pwr_q       <= pwr_d;
      halted_q    <= halted_d;
`ifdef SINGLE_STEP_EN
      step_prev_q <= step_prev_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    hold_d      = '0;
    cont_prev_d = continue_req;
`ifdef SINGLE_STEP_EN
    step_prev_d = step;
`endif
    cnt_d       = cpu_en_q ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      S_INIT: begin
        if (hold_q >= HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_RUN: begin
        if (halt_req) state_d = S_HALT;
      end
      S_HALT: begin
        if (cont_rise) begin
          state_d = S_RUN;
`ifdef SINGLE_STEP_EN
        end else if (step_rise) begin
          state_d = S_STEP;
`endif
        end
      end
`ifdef SINGLE_STEP_EN
      S_STEP: state_d = S_HALT;
`endif
      default: state_d = S_INIT;
    endcase
  end

  // Moore outputs, registered from the next state so they line up with state_q
  always_comb begin
    cpu_rst_d = (state_d == S_INIT);
    cpu_en_d  = (state_d == S_RUN) || (state_d == S_STEP);
    pwr_d     = (state_d != S_INIT);
    halted_d  = (state_d == S_HALT);
  end

  assign cpu_rst   = cpu_rst_q;
  assign cpu_en    = cpu_en_q;
  assign pwr       = pwr_q;
  assign halted    = halted_q;
  assign cycle_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed, table-driven bench for cpu_run_ctrl (default 32-bit counter plus a 4-bit wrap instance).
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cont = 1'b0;
  logic        halt = 1'b0;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic        cpu_rst, cpu_en, pwr, halted;
  logic [31:0] cycle_cnt;
  logic [1:0]  state;
  logic        w_cpu_rst, w_cpu_en, w_pwr, w_halted;
  logic [3:0]  w_cycle_cnt;
  logic [1:0]  w_state;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.RST_HOLD(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .continue_req(cont), .halt_req(halt),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .pwr(pwr), .halted(halted),
    .cycle_cnt(cycle_cnt), .state(state)
  );

  cpu_run_ctrl #(.RST_HOLD(4), .CNT_W(4)) u_wrap (
    .clk(clk), .rst(rst), .continue_req(cont), .halt_req(halt),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .cpu_rst(w_cpu_rst), .cpu_en(w_cpu_en), .pwr(w_pwr), .halted(w_halted),
    .cycle_cnt(w_cycle_cnt), .state(w_state)
  );

  typedef struct {
    logic        rst, cont, halt;
    logic [1:0]  st;
    logic        crst, en, pwr, hlt;
    logic [31:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic c, input logic h, input logic [1:0] st,
                     input logic crst, input logic en, input logic p, input logic hl,
                     input logic [31:0] cnt);
    vec_t v;
    v.rst = r; v.cont = c; v.halt = h; v.st = st;
    v.crst = crst; v.en = en; v.pwr = p; v.hlt = hl; v.cnt = cnt;
    tv.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic crst,
                           input logic en, input logic p, input logic hl, input logic [31:0] cnt);
    check({tag, ".state"},     32'(state),     32'(st));
    check({tag, ".cpu_rst"},   32'(cpu_rst),   32'(crst));
    check({tag, ".cpu_en"},    32'(cpu_en),    32'(en));
    check({tag, ".pwr"},       32'(pwr),       32'(p));
    check({tag, ".halted"},    32'(halted),    32'(hl));
    check({tag, ".cycle_cnt"}, cycle_cnt,      cnt);
    check({tag, ".w_state"},   32'(w_state),   32'(st));
    check({tag, ".w_cnt"},     32'(w_cycle_cnt), cnt & 32'hF);
  endtask

  initial begin
    // rst cont halt | state crst en pwr hlt cnt
    add(1, 0, 0, 2'd0, 1, 0, 0, 0, 0);   // reset
    add(0, 0, 0, 2'd0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 2'd0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 2'd0, 1, 0, 0, 0, 0);   // 4th cpu_rst cycle
    add(0, 0, 0, 2'd1, 0, 1, 1, 0, 0);   // RUN, counter not yet advanced
    add(0, 0, 0, 2'd1, 0, 1, 1, 0, 1);
    add(0, 0, 0, 2'd1, 0, 1, 1, 0, 2);
    add(0, 1, 0, 2'd1, 0, 1, 1, 0, 3);   // continue edge ignored in RUN
    for (int i = 4; i <= 10; i++) add(0, 1, 0, 2'd1, 0, 1, 1, 0, 32'(i));
    add(0, 1, 1, 2'd2, 0, 0, 1, 1, 11);  // halt_req in 11th run cycle
    add(0, 1, 0, 2'd2, 0, 0, 1, 1, 11);  // continue still high: no resume
    add(0, 1, 1, 2'd2, 0, 0, 1, 1, 11);  // halt_req ignored in HALT
    add(0, 0, 0, 2'd2, 0, 0, 1, 1, 11);
    add(0, 1, 0, 2'd1, 0, 1, 1, 0, 11);  // fresh edge resumes
    add(0, 1, 0, 2'd1, 0, 1, 1, 0, 12);
    add(0, 1, 1, 2'd2, 0, 0, 1, 1, 13);
    add(0, 0, 0, 2'd2, 0, 0, 1, 1, 13);
    add(0, 1, 0, 2'd1, 0, 1, 1, 0, 13);
    add(1, 1, 0, 2'd0, 1, 0, 0, 0, 0);   // reset mid-RUN
    add(0, 1, 0, 2'd0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 2'd0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 2'd0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 2'd1, 0, 1, 1, 0, 0);

    foreach (tv[i]) begin
      rst = tv[i].rst; cont = tv[i].cont; halt = tv[i].halt;
      cycle();
      check_all($sformatf("v%0d", i), tv[i].st, tv[i].crst, tv[i].en, tv[i].pwr,
                tv[i].hlt, tv[i].cnt);
    end

    // 16 run cycles: 4-bit counter wraps to 0
    rst = 1'b0; halt = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      check($sformatf("wrap%0d.cnt", i), cycle_cnt, 32'(i));
      check($sformatf("wrap%0d.w_cnt", i), 32'(w_cycle_cnt), 32'(i % 16));
    end

    halt = 1'b1; cycle();
    check_all("halt2", 2'd2, 0, 0, 1, 1, 17);
    halt = 1'b0; cont = 1'b0; cycle();
    check_all("halt3", 2'd2, 0, 0, 1, 1, 17);

`ifdef SINGLE_STEP_EN
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; cycle();
      check_all($sformatf("step%0d.a", k), 2'd3, 0, 1, 1, 0, 32'(17 + k));
      step = 1'b0; cycle();
      check_all($sformatf("step%0d.b", k), 2'd2, 0, 0, 1, 1, 32'(18 + k));
    end
    cont = 1'b1; step = 1'b1; cycle();
    check_all("cont_wins", 2'd1, 0, 1, 1, 0, 20);
    cont = 1'b0; step = 1'b0;
`else
    cont = 1'b1; cycle();
    check_all("resume2", 2'd1, 0, 1, 1, 0, 17);
    cont = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
